// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and encodings for the program-counter controller.
//   pc_op_e  : control-flow op carried from execute
//   state_e  : controller FSM states
//   ASEL_*/BSEL_* : operand selects of the target adder
//   RESET_PC_DEF  : default reset PC
package pc_ctrl_pkg;
   typedef enum logic [2:0] {
      OP_SEQ, OP_JAL, OP_JALR, OP_BRANCH, OP_ECALL, OP_MRET, OP_HALT, OP_RSVD
   } pc_op_e;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
   localparam logic [1:0] ASEL_4    = 2'd0;
   localparam logic [1:0] ASEL_IMM  = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;
   localparam logic [1:0] BSEL_PC   = 2'd0;
   localparam logic [1:0] BSEL_RS1  = 2'd1;
   localparam logic [1:0] BSEL_CSR  = 2'd2;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC adder, target = A + B (mod 2^32).
//   pc, imm, rf_busA, csr_busA : candidate operands
//   asel : A operand (const 4 / imm / zero);  bsel : B operand (pc / rs1 / csr)
//   clr_lsb : clear bit 0 of the sum (jalr)
//   target : computed PC;  misalign : target[1:0] != 0
module pc_target_calc
   import pc_ctrl_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rf_busA,
   input  logic [31:0] csr_busA,
   input  logic [1:0]  asel,
   input  logic [1:0]  bsel,
   input  logic        clr_lsb,
   output logic [31:0] target,
   output logic        misalign
);
   logic [31:0] a, b, sum;
   always_comb begin
      a        = asel == ASEL_IMM ? imm : asel == ASEL_ZERO ? 32'd0 : 32'd4;
      b        = bsel == BSEL_RS1 ? rf_busA : bsel == BSEL_CSR ? csr_busA : pc;
      sum      = a + b;
      target   = clr_lsb ? {sum[31:1], 1'b0} : sum;
      misalign = |target[1:0];
   end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: multi-cycle PC controller; offers PC to fetch, takes execute outcome, computes next PC.
//   ifu_pc/ifu_valid/ifu_ready : PC offer to fetch
//   exu_valid/exu_ready, pc_op, br_taken, imm, rf_busA, csr_busA : execute outcome
//   pc_asel/pc_bsel : current target operand selects
//   halted/halt_err : sticky halt status;  instret : retired-instruction count
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ifu_pc,
   output logic        ifu_valid,
   input  logic        ifu_ready,
   input  logic        exu_valid,
   output logic        exu_ready,
   input  logic [2:0]  pc_op,
   input  logic        br_taken,
   input  logic [31:0] imm,
   input  logic [31:0] rf_busA,
   input  logic [31:0] csr_busA,
   output logic [1:0]  pc_asel,
   output logic [1:0]  pc_bsel,
   output logic        halted,
   output logic        halt_err,
   output logic [31:0] instret
);
   state_e      state, state_n;
   pc_op_e      op;
   logic [31:0] target;
   logic        misalign, accept, err, stop;

   assign op = pc_op_e'(pc_op);

   pc_target_calc u_calc (
      .pc(ifu_pc), .imm(imm), .rf_busA(rf_busA), .csr_busA(csr_busA),
      .asel(pc_asel), .bsel(pc_bsel), .clr_lsb(op == OP_JALR),
      .target(target), .misalign(misalign)
   );

   always_comb begin
      pc_asel = (op == OP_JAL || op == OP_JALR || (op == OP_BRANCH && br_taken)) ? ASEL_IMM :
                (op == OP_ECALL || op == OP_MRET) ? ASEL_ZERO : ASEL_4;
      pc_bsel = op == OP_JALR ? BSEL_RS1 : (op == OP_ECALL || op == OP_MRET) ? BSEL_CSR : BSEL_PC;
      accept  = state == S_EXEC && exu_valid;
      // HALT's own target is never taken, so its alignment does not matter
      err     = op == OP_RSVD || (op != OP_HALT && misalign);
      stop    = op == OP_HALT || err;
      state_n = state == S_IDLE ? S_FETCH :
                (state == S_FETCH && ifu_valid && ifu_ready) ? S_EXEC :
                accept ? (stop ? S_HALT : S_FETCH) : state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ifu_pc    <= RESET_PC;
         ifu_valid <= 1'b0;
         exu_ready <= 1'b0;
         halted    <= 1'b0;
         halt_err  <= 1'b0;
         instret   <= '0;
      end else begin
         state     <= state_n;
         ifu_valid <= state_n == S_FETCH;
         exu_ready <= state_n == S_EXEC;
         halted    <= halted | (state_n == S_HALT);
         if (accept && !stop) ifu_pc <= target;
         if (accept && !err) instret <= instret + 32'd1;
         if (accept && err) halt_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl with a per-cycle reference model.
module tb_pc_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] ifu_pc, imm = '0, rf_busA = '0, csr_busA = '0, instret;
   logic        ifu_valid, ifu_ready = 1'b1, exu_valid = 1'b0, exu_ready, br_taken = 1'b0;
   logic [2:0]  pc_op = '0;
   logic [1:0]  pc_asel, pc_bsel;
   logic        halted, halt_err;
   int          n_chk = 0, n_fail = 0;

   pc_ctrl dut (
      .clk(clk), .rst(rst), .ifu_pc(ifu_pc), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .pc_op(pc_op), .br_taken(br_taken),
      .imm(imm), .rf_busA(rf_busA), .csr_busA(csr_busA), .pc_asel(pc_asel), .pc_bsel(pc_bsel),
      .halted(halted), .halt_err(halt_err), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: phase 0 idle, 1 waiting fetch, 2 waiting execute, 3 halted
   int          m_phase;
   logic [31:0] m_pc, m_inst;
   logic        m_halted, m_err, m_on = 1'b0;

   function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] pc,
                                              input logic [31:0] im, input logic [31:0] rs1,
                                              input logic [31:0] csr, input logic tk);
      case (op)
         3'd1:    return pc + im;
         3'd2:    return (rs1 + im) & 32'hFFFF_FFFE;
         3'd3:    return tk ? pc + im : pc + 32'd4;
         3'd4,
         3'd5:    return csr;
         default: return pc + 32'd4;
      endcase
   endfunction

   function automatic logic [1:0] ref_asel(input logic [2:0] op, input logic tk);
      if (op == 3'd1 || op == 3'd2 || (op == 3'd3 && tk)) return 2'd1;
      if (op == 3'd4 || op == 3'd5) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [1:0] ref_bsel(input logic [2:0] op);
      if (op == 3'd2) return 2'd1;
      if (op == 3'd4 || op == 3'd5) return 2'd2;
      return 2'd0;
   endfunction

   always @(posedge clk) begin
      logic [31:0] t;
      if (rst) begin
         m_on = 1'b1; m_phase = 0; m_pc = 32'h8000_0000; m_inst = 0; m_halted = 0; m_err = 0;
      end else if (m_on) begin
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1) begin
            if (ifu_ready) m_phase = 2;
         end else if (m_phase == 2 && exu_valid) begin
            t = ref_target(pc_op, m_pc, imm, rf_busA, csr_busA, br_taken);
            if (pc_op == 3'd6) begin
               m_inst = m_inst + 1; m_phase = 3; m_halted = 1;
            end else if (pc_op == 3'd7 || t[1:0] != 2'b00) begin
               m_phase = 3; m_halted = 1; m_err = 1;
            end else begin
               m_pc = t; m_inst = m_inst + 1; m_phase = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("m_pc", ifu_pc, m_pc);
         chk("m_ifu_valid", 32'(ifu_valid), 32'(m_phase == 1));
         chk("m_exu_ready", 32'(exu_ready), 32'(m_phase == 2));
         chk("m_halted", 32'(halted), 32'(m_halted));
         chk("m_halt_err", 32'(halt_err), 32'(m_err));
         chk("m_instret", instret, m_inst);
         chk("m_asel", 32'(pc_asel), 32'(ref_asel(pc_op, br_taken)));
         chk("m_bsel", 32'(pc_bsel), 32'(ref_bsel(pc_op)));
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] im, input logic [31:0] rs1,
                         input logic [31:0] csr, input logic tk);
      int n = 0;
      ifu_ready = 1'b1;
      while (!ifu_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("fetch_timeout", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      pc_op = op; imm = im; rf_busA = rs1; csr_busA = csr; br_taken = tk; exu_valid = 1'b1;
      @(posedge clk); #1;
      exu_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; exu_valid = 1'b0; pc_op = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(ifu_valid), 32'd0);
      chk("rst_pc", ifu_pc, 32'h8000_0000);
      chk("rst_instret", instret, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("first_valid", 32'(ifu_valid), 32'd1);
      run_op(3'd0, 0, 0, 0, 0); chk("seq1", ifu_pc, 32'h8000_0004);
      run_op(3'd0, 0, 0, 0, 0); chk("seq2", ifu_pc, 32'h8000_0008);
      run_op(3'd0, 0, 0, 0, 0); chk("seq3", ifu_pc, 32'h8000_000C);
      chk("instret3", instret, 32'd3);
      run_op(3'd0, 0, 0, 0, 0); chk("seq4", ifu_pc, 32'h8000_0010);
      pc_op = 3'd3; br_taken = 1'b1; imm = 32'hFFFF_FFF0; #1;
      chk("asel_taken", 32'(pc_asel), 32'd1);
      br_taken = 1'b0; #1;
      chk("asel_not_taken", 32'(pc_asel), 32'd0);
      run_op(3'd3, 32'hFFFF_FFF0, 0, 0, 1); chk("br_taken", ifu_pc, 32'h8000_0000);
      run_op(3'd1, 32'd16, 0, 0, 0); chk("jal", ifu_pc, 32'h8000_0010);
      run_op(3'd3, 32'hFFFF_FFF0, 0, 0, 0); chk("br_not_taken", ifu_pc, 32'h8000_0014);
      run_op(3'd4, 0, 0, 32'h8000_0100, 0); chk("ecall", ifu_pc, 32'h8000_0100);
      run_op(3'd5, 0, 0, 32'h8000_0040, 0); chk("mret", ifu_pc, 32'h8000_0040);
      ifu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exu_valid = (i == 2); pc_op = 3'd1; imm = 32'h100;
         @(posedge clk); #1;
         chk("stall_pc", ifu_pc, 32'h8000_0040);
         chk("stall_exu_ready", 32'(exu_ready), 32'd0);
      end
      exu_valid = 1'b0;
      run_op(3'd0, 0, 0, 0, 0); chk("after_stall", ifu_pc, 32'h8000_0044);
      @(posedge clk); #1;
      exu_valid = 1'b1; pc_op = 3'd0; rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_pc", ifu_pc, 32'h8000_0000);
      chk("mid_rst_instret", instret, 32'd0);
      chk("mid_rst_valid", 32'(ifu_valid), 32'd0);
      chk("mid_rst_ready", 32'(exu_ready), 32'd0);
      rst = 1'b0; exu_valid = 1'b0;
      run_op(3'd6, 0, 0, 0, 0);
      chk("halt", 32'(halted), 32'd1);
      chk("halt_noerr", 32'(halt_err), 32'd0);
      chk("halt_instret", instret, 32'd1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("halt_novalid", 32'(ifu_valid), 32'd0);
      end
      do_reset();
      run_op(3'd1, 32'h7FFF_FFFC, 0, 0, 0); chk("jal_top", ifu_pc, 32'hFFFF_FFFC);
      run_op(3'd0, 0, 0, 0, 0); chk("wrap", ifu_pc, 32'h0000_0000);
      run_op(3'd2, 32'd2, 32'h8000_1001, 0, 0);
      chk("jalr_mis_halted", 32'(halted), 32'd1);
      chk("jalr_mis_err", 32'(halt_err), 32'd1);
      chk("jalr_mis_pc", ifu_pc, 32'h0000_0000);
      chk("jalr_mis_instret", instret, 32'd2);
      do_reset();
      run_op(3'd2, 32'd4, 32'h8000_1001, 0, 0); chk("jalr_ok", ifu_pc, 32'h8000_1004);
      run_op(3'd7, 0, 0, 0, 0);
      chk("rsvd_err", 32'(halt_err), 32'd1);
      chk("rsvd_instret", instret, 32'd1);
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
